// File: rtl/mem_bus_arbiter_if.sv
// Request/response and memory-side bundle for mem_bus_arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface mem_bus_arbiter_if #(
  parameter int WIDTH       = 32,
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]       req_valid;
  logic [NUM_MASTERS-1:0]       req_write;
  logic [NUM_MASTERS*WIDTH-1:0] req_addr;
  logic [NUM_MASTERS*WIDTH-1:0] req_wdata;
  logic [NUM_MASTERS*4-1:0]     req_byteen;
  logic [NUM_MASTERS-1:0]       req_ready;
  logic [NUM_MASTERS-1:0]       rsp_valid;
  logic [WIDTH-1:0]             rsp_rdata;
  logic                         rsp_err;
  logic                         mem_read;
  logic                         mem_write;
  logic [WIDTH-1:0]             mem_addr;
  logic [WIDTH-1:0]             mem_wdata;
  logic [3:0]                   mem_byteen;
  logic [WIDTH-1:0]             mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_byteen, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, mem_read, mem_write,
    output mem_addr, mem_wdata, mem_byteen
  );

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_byteen, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, mem_read, mem_write,
    input  mem_addr, mem_wdata, mem_byteen
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin N-master arbiter onto a single-ported memory bus.
// Optional MEM_BUS_ALIGN_CHECK_EN rejects misaligned/empty requests.
module mem_bus_arbiter #(
  parameter int WIDTH       = 32,
  parameter int NUM_MASTERS = 2,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int N  = NUM_MASTERS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gnt;
  logic [PW-1:0]    gnt_q;
  logic             gnt_vld;
  logic             accept;
  logic             bad;
  logic [3:0]       cnt;
  logic             wr_q;
  logic             err_q;
  logic [N-1:0]     rsp_valid_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [3:0]       be_q;
  logic             sel_wr;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic [3:0]       sel_be;

  function automatic logic [N-1:0] onehot(
    input logic [PW-1:0] g
  );
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // First valid master at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N)
        idx = idx - N;
      if (!gnt_vld && bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = PW'(idx);
      end
    end
  end

  assign sel_wr    = bus.req_write[gnt];
  assign sel_addr  = bus.req_addr[int'(gnt)*WIDTH +: WIDTH];
  assign sel_wdata = bus.req_wdata[int'(gnt)*WIDTH +: WIDTH];
  assign sel_be    = bus.req_byteen[int'(gnt)*4 +: 4];

`ifdef MEM_BUS_ALIGN_CHECK_EN
  // An enabled byte that lands past lane 3 after the offset crosses words.
  always_comb begin
    bad = (sel_be == 4'b0000);
    for (int b = 0; b < 4; b++)
      if (sel_be[b] && (b + int'(sel_addr[1:0])) > 3)
        bad = 1'b1;
  end
`else
  assign bad = 1'b0;
`endif

  assign accept = (state == IDLE) && gnt_vld && !reset;

  always_comb begin
    bus.req_ready = '0;
    if (accept)
      bus.req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_q       <= '0;
      cnt         <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            gnt_q <= gnt;
            wr_q  <= sel_wr;
            cnt   <= 4'(MEM_LATENCY - 1);
            if (bad) begin
              err_q       <= 1'b1;
              rsp_valid_q <= onehot(gnt);
              state       <= RESP;
            end else begin
              addr_q      <= sel_addr;
              wdata_q     <= sel_wdata;
              be_q        <= sel_be;
              mem_read_q  <= !sel_wr;
              mem_write_q <= sel_wr;
              state       <= ACCESS;
            end
          end
        end
        ACCESS: begin
          mem_write_q <= 1'b0;
          if (cnt == 4'd0) begin
            mem_read_q  <= 1'b0;
            rsp_valid_q <= onehot(gnt_q);
            state       <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          err_q       <= 1'b0;
          wr_q        <= 1'b0;
          addr_q      <= '0;
          wdata_q     <= '0;
          be_q        <= '0;
          if (int'(gnt_q) == N - 1)
            rr_ptr <= '0;
          else
            rr_ptr <= gnt_q + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data passes straight through in RESP; memory has it ready then.
  assign bus.rsp_rdata =
    (state == RESP && !wr_q && !err_q) ? bus.mem_rdata : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_byteen = be_q;

`ifdef MEM_BUS_ALIGN_CHECK_EN
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised N-master arbiter sitting between one or more bus masters (multicycle core instruction/data ports, debug or DMA agents) and the single-ported `memory_bus`. It replaces the direct core-to-bus wiring with a valid/ready request channel per master, round-robin arbitration, a configurable memory wait-state count and a per-master response strobe. One transaction is in flight at a time.

## Interface
- `WIDTH`, 32, data/address width in bits.
- `NUM_MASTERS`, 2, number of requesting masters (1..8).
- `MEM_LATENCY`, 1, cycles from address presentation to valid `mem_rdata` (1..15).
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_MASTERS  per-master request valid.
- `req_write`  in  NUM_MASTERS  1 = write, 0 = read.
- `req_addr`  in  NUM_MASTERS*WIDTH  packed addresses, master i at `[i*WIDTH +: WIDTH]`.
- `req_wdata`  in  NUM_MASTERS*WIDTH  packed write data.
- `req_byteen`  in  NUM_MASTERS*4  packed byte enables.
- `req_ready`  out  NUM_MASTERS  one-hot; request of master i accepted this cycle.
- `rsp_valid`  out  NUM_MASTERS  one-hot; response for master i this cycle.
- `rsp_rdata`  out  WIDTH  read data, shared; valid only with a `rsp_valid` bit.
- `rsp_err`  out  1  response error flag (see Configuration); 0 when macro absent.
- `mem_read`, `mem_write`  out  1  strobes to `memory_bus`.
- `mem_addr`, `mem_wdata`  out  WIDTH  address/write data to `memory_bus`.
- `mem_byteen`  out  4  byte enables to `memory_bus`.
- `mem_rdata`  in  WIDTH  read data from `memory_bus`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `req_valid`, grant g = first set bit searching from `rr_ptr` upward, wrapping at NUM_MASTERS. `req_ready[g]`=1 combinationally that cycle; latch g, write, addr, wdata, byteen; go ACCESS. No valid: stay IDLE, all outputs 0.
- ACCESS: drive latched addr/wdata/byteen for MEM_LATENCY cycles (down-counter, width $clog2(16)). Read: `mem_read`=1 every ACCESS cycle. Write: `mem_write`=1 on first ACCESS cycle only. Counter hits 0 -> RESP.
- RESP: `rsp_valid[g]`=1; `rsp_rdata` = `mem_rdata` for reads, 0 for writes; mem strobes 0. `rr_ptr` <= (g+1) mod NUM_MASTERS; -> IDLE.
- Masters hold request stable until `req_ready`; dropping `req_valid` before grant is legal (no effect).
- Request arriving during ACCESS/RESP waits; never accepted before IDLE.
- NUM_MASTERS=1: arbiter degenerates to pass-through with same timing.

## Timing
- Reset: state IDLE, `rr_ptr`=0, counter 0, all outputs 0 (`req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, all `mem_*`).
- Reset asserted mid-ACCESS/RESP: aborts on next edge, no `rsp_valid` issued; an in-progress write may already have occurred.
- Accept at cycle T0; ACCESS T1..T(MEM_LATENCY); RESP T(MEM_LATENCY+1); next accept earliest T(MEM_LATENCY+2).
- Throughput: one transaction per MEM_LATENCY+2 cycles.
- Fairness: with all masters continuously valid, grants rotate 0,1,...,N-1,0; no master waits more than N-1 transactions.

## Configuration
- `MEM_BUS_ALIGN_CHECK_EN` defined: in IDLE, accepted request with `req_addr[1:0]`!=0 and byteen spanning beyond the word, or any byteen=0, is flagged: skip ACCESS (no mem strobes), go straight to RESP next cycle with `rsp_err`=1, `rsp_rdata`=0. Pointer advances normally.
- Not defined: no check, `rsp_err` tied 0, all requests go to memory.

## Test plan
- Reset then single read: master 0 reads 0x100 (mem holds 0xDEADBEEF), MEM_LATENCY=1 -> `req_ready[0]` at T0, `mem_read` at T1, `rsp_valid[0]`=1 with 0xDEADBEEF at T2.
- Write byteen: master 1 writes 0x12345678 to 0x200, byteen 4'b0011 -> single `mem_write` pulse at T1; later read returns 0x????5678 with upper bytes unchanged.
- Round-robin: 3 masters all valid continuously -> grant order 0,1,2,0,1,2; accepts every MEM_LATENCY+2 cycles.
- Latency sweep: MEM_LATENCY=3 -> `mem_read` high T1..T3, `rsp_valid` at T4.
- Reset mid-ACCESS: assert `reset` at T1 of read -> next cycle all outputs 0, no `rsp_valid`, next request granted to master 0.
- With `MEM_BUS_ALIGN_CHECK_EN`: read at 0x102 byteen 4'b1111 -> no mem strobe, `rsp_valid` + `rsp_err`=1 at T1, `rsp_rdata`=0.
